// File: rtl/dense1_sigmoid.sv
// dense1_sigmoid: 3-stage PLAN sigmoid on the dense-1 stream with realigned frame markers and frame-length check
module dense1_sigmoid #(
  parameter int DATA_W = 16,
  parameter int N_ELEM = 120,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              frame_start_in,
  input  logic              frame_end_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              frame_start_out,
  output logic              frame_end_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              len_err
);
  logic              w_s;
  logic [DATA_W-1:0] w_a;
  logic [1:0]        w_rg;
  logic [8:0]        w_y;
  logic [8:0]        w_d;
  logic [CNT_W-1:0]  w_cn;
  logic              r1_s, r1_fs, r1_fe, r1_v;
  logic [1:0]        r1_rg;
  logic [8:0]        r1_a;
  logic              r2_s, r2_fs, r2_fe, r2_v;
  logic [8:0]        r2_y;
  logic [CNT_W-1:0]  r_cnt;
  assign w_s  = data_in[DATA_W-1];
  assign w_a  = data_in == {1'b1, {(DATA_W-1){1'b0}}} ? {1'b0, {(DATA_W-1){1'b1}}} :
                w_s ? -data_in : data_in;
  assign w_rg = w_a >= DATA_W'(1280) ? 2'd3 : w_a >= DATA_W'(608) ? 2'd2 :
                w_a >= DATA_W'(256) ? 2'd1 : 2'd0;
  // r1_a keeps a[10:2]: every non-saturated region only needs those bits
  assign w_y  = r1_rg == 2'd3 ? 9'd256 :
                r1_rg == 2'd2 ? {3'b0, r1_a[8:3]} + 9'd216 :
                r1_rg == 2'd1 ? {2'b0, r1_a[7:1]} + 9'd160 :
                                {3'b0, r1_a[5:0]} + 9'd128;
  assign w_d  = r2_s ? 9'd256 - r2_y : r2_y;
  assign w_cn = r2_fs ? CNT_W'(1) : &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      {r1_s, r1_fs, r1_fe, r1_v, r1_rg, r1_a} <= '0;
      {r2_s, r2_fs, r2_fe, r2_v, r2_y}        <= '0;
      {frame_start_out, frame_end_out, valid_out, len_err} <= '0;
      data_out <= '0;
      r_cnt    <= '0;
    end else if (ena) begin
      r1_s  <= w_s;
      r1_a  <= w_a[10:2];
      r1_rg <= w_rg;
      r1_fs <= frame_start_in;
      r1_fe <= frame_end_in;
      r1_v  <= valid_in;
      r2_s  <= r1_s;
      r2_y  <= w_y;
      r2_fs <= r1_fs;
      r2_fe <= r1_fe;
      r2_v  <= r1_v;
      data_out        <= {{(DATA_W-9){1'b0}}, w_d};
      frame_start_out <= r2_fs;
      frame_end_out   <= r2_fe;
      valid_out       <= r2_v;
      len_err         <= r2_v & r2_fe & (w_cn != CNT_W'(N_ELEM));
      if (r2_v) r_cnt <= r2_fe ? '0 : w_cn;
    end
  end
endmodule

// File: tb/tb_dense1_sigmoid.sv
// tb_dense1_sigmoid: directed scoreboard bench for dense1_sigmoid
module tb_dense1_sigmoid;
  logic clk = 0, rst = 1, ena = 1, fs_i = 0, fe_i = 0, v_i = 0;
  logic [15:0] d_i = 0;
  logic fs_o, fe_o, v_o, le_o;
  logic [15:0] d_o;
  int checks = 0, errors = 0, ec = 0, mcnt = 0;
  logic en_s, rs_s;
  logic [19:0] prev;
  typedef struct {logic [15:0] d; logic fs, fe, le; int ec;} exp_t;
  exp_t q[$];
  exp_t e;
  int tx[9] = '{0, 100, 256, -256, 512, 800, 1280, -1280, -32768};
  int te[9] = '{128, 153, 192, 64, 224, 241, 256, 0, 0};

  dense1_sigmoid dut (
    .clk(clk), .rst(rst), .ena(ena), .frame_start_in(fs_i), .frame_end_in(fe_i),
    .valid_in(v_i), .data_in(d_i), .frame_start_out(fs_o), .frame_end_out(fe_o),
    .valid_out(v_o), .data_out(d_o), .len_err(le_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  function automatic logic [15:0] sig(input logic [15:0] x);
    int a, y;
    a = $signed(x);
    if (a < 0) a = -a;
    if (a > 32767) a = 32767;
    y = a >= 1280 ? 256 : a >= 608 ? a / 32 + 216 : a >= 256 ? a / 8 + 160 : a / 4 + 128;
    return 16'(x[15] ? 256 - y : y);
  endfunction

  always @(posedge clk) begin
    en_s = ena;
    rs_s = rst;
    if (en_s && !rs_s) ec++;
    #1;
    if (rs_s) chk("reset", {fs_o, fe_o, v_o, le_o, d_o}, 0);
    else if (!en_s) chk("frozen", {fs_o, fe_o, v_o, le_o, d_o}, prev);
    else if (v_o) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", d_o, e.d);
        chk("markers", {fs_o, fe_o}, {e.fs, e.fe});
        chk("len_err", le_o, e.le);
        chk("latency", ec - e.ec, 3);
      end
    end else chk("idle", {fs_o, fe_o, le_o}, 0);
    prev = {fs_o, fe_o, v_o, le_o, d_o};
  end

  task automatic step(input logic v, input logic s, input logic f, input logic [15:0] x,
                      input logic [15:0] ex, input logic en);
    int nx;
    @(negedge clk);
    rst = 0; ena = en; v_i = v; fs_i = s; fe_i = f; d_i = x;
    if (en && v) begin
      nx = (s ? 0 : mcnt) + 1;
      if (nx > 127) nx = 127;
      q.push_back('{ex, s, f, f && nx != 120, ec});
      mcnt = f ? 0 : nx;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1; ena = 1'($urandom); v_i = 1'($urandom); fs_i = 1'($urandom);
      fe_i = 1'($urandom); d_i = 16'($urandom);
      q.delete();
      mcnt = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'($urandom), 0, 1);
  endtask

  task automatic frame(input int n, input bit s, input bit f);
    logic [15:0] x;
    for (int i = 0; i < n; i++) begin
      x = i % 3 == 0 ? 16'($urandom_range(0, 3000)) - 16'd1500 : 16'($urandom);
      step(1, s && i == 0, f && i == n - 1, x, sig(x), 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d_i = 16'($urandom);
    do_reset(2);
    idle(5);
    for (int i = 0; i < 9; i++) step(1, i == 0, i == 8, 16'(tx[i]), 16'(te[i]), 1);
    idle(3);
    frame(120, 1, 1);
    frame(119, 1, 1);
    frame(121, 1, 1);
    frame(120, 1, 1);
    idle(2);
    step(1, 1, 1, 16'd300, sig(16'd300), 1);
    frame(50, 1, 0);
    frame(120, 1, 1);
    frame(200, 1, 1);
    frame(120, 1, 1);
    frame(5, 0, 1);
    frame(60, 1, 0);
    for (int i = 0; i < 5; i++) step(1'($urandom), 0, 0, 16'($urandom), 0, 0);
    frame(60, 0, 1);
    idle(1);
    frame(60, 1, 0);
    do_reset(1);
    frame(120, 1, 1);
    idle(6);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
